// File: rtl/xnor_pattern_matcher.sv
// xnor_pattern_matcher
// Serial pattern matcher built on the bitwise XNOR equality primitive.
// A 1-bit stream is shifted into a WIDTH-bit window (newest bit at LSB,
// oldest at MSB). Each enabled sample compares the window against a
// programmable pattern under a per-bit care mask.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   en          sample enable; din is shifted in only when en=1
//   din         serial data bit
//   pattern     reference pattern; pattern[WIDTH-1] matches the oldest bit
//   mask        1 = care, 0 = don't-care per bit position
//   cnt_clr     synchronous clear of match_count
//   match       registered one-cycle pulse on a full masked match
//   score       number of care positions that agree in the current window
//   match_count saturating count of matches
//   primed      window holds WIDTH valid bits since last reset or refill
module xnor_pattern_matcher #(
  parameter int WIDTH   = 4,
  parameter int CNT_W   = 8,
  parameter int OVERLAP = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       din,
  input  logic [WIDTH-1:0]           pattern,
  input  logic [WIDTH-1:0]           mask,
  input  logic                       cnt_clr,
  output logic                       match,
  output logic [$clog2(WIDTH+1)-1:0] score,
  output logic [CNT_W-1:0]           match_count,
  output logic                       primed
);

  localparam int SCORE_W = $clog2(WIDTH + 1);
  localparam int FILL_W  = $clog2(WIDTH + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  // Non-overlapping mode empties the fill count after every match.
  localparam bit REFILL = (OVERLAP == 0);

  logic [WIDTH-1:0]   win_r;
  logic [FILL_W-1:0]  fill_r;
  logic               match_r;
  logic [SCORE_W-1:0] score_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               primed_r;

  logic [WIDTH-1:0]   win_n_s;
  logic [FILL_W-1:0]  fill_n_s;
  logic [WIDTH-1:0]   eq_s;
  logic [WIDTH-1:0]   agree_s;
  logic               hit_s;

  // Number of set bits in a window-wide vector.
  function automatic logic [SCORE_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [SCORE_W-1:0] c;
    c = {SCORE_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      c = c + SCORE_W'(v[i]);
    end
    return c;
  endfunction

  // Next window/fill and the masked XNOR comparison against that next window.
  always_comb begin
    win_n_s = {win_r[WIDTH-2:0], din};
    if (fill_r == FILL_MAX) begin
      fill_n_s = FILL_MAX;
    end else begin
      fill_n_s = fill_r + FILL_W'(1);
    end
    // Don't-care positions always read as equal for the match decision,
    // but never contribute to the score.
    eq_s    = ~(win_n_s ^ pattern) | ~mask;
    agree_s = ~(win_n_s ^ pattern) & mask;
    hit_s   = en & (&eq_s) & (fill_n_s == FILL_MAX);
  end

  // Window, fill, outputs and saturating match counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_r    <= {WIDTH{1'b0}};
      fill_r   <= {FILL_W{1'b0}};
      match_r  <= 1'b0;
      score_r  <= {SCORE_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      primed_r <= 1'b0;
    end else begin
      if (en) begin
        win_r   <= win_n_s;
        match_r <= hit_s;
        score_r <= popcount(agree_s);
        if (REFILL && hit_s) begin
          fill_r   <= {FILL_W{1'b0}};
          primed_r <= 1'b0;
        end else begin
          fill_r   <= fill_n_s;
          primed_r <= (fill_n_s == FILL_MAX);
        end
      end else begin
        match_r <= 1'b0;
      end
      // Clear takes priority, but a coincident match still counts as one.
      if (cnt_clr) begin
        cnt_r <= CNT_W'(hit_s);
      end else if (hit_s && (cnt_r != CNT_MAX)) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign match       = match_r;
  assign score       = score_r;
  assign match_count = cnt_r;
  assign primed      = primed_r;

endmodule

// File: tb/tb_xnor_pattern_matcher.sv
module tb_xnor_pattern_matcher;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst, en, din, cnt_clr;
  logic [W-1:0] pattern, mask;

  logic       match0, match1, match2;
  logic [2:0] score0, score1, score2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;
  logic       primed0, primed1, primed2;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  // Three configurations share one stimulus stream.
  xnor_pattern_matcher #(.WIDTH(W), .CNT_W(8), .OVERLAP(1)) u0 (
    .clk(clk), .rst(rst), .en(en), .din(din), .pattern(pattern), .mask(mask),
    .cnt_clr(cnt_clr), .match(match0), .score(score0), .match_count(cnt0), .primed(primed0));
  xnor_pattern_matcher #(.WIDTH(W), .CNT_W(8), .OVERLAP(0)) u1 (
    .clk(clk), .rst(rst), .en(en), .din(din), .pattern(pattern), .mask(mask),
    .cnt_clr(cnt_clr), .match(match1), .score(score1), .match_count(cnt1), .primed(primed1));
  xnor_pattern_matcher #(.WIDTH(W), .CNT_W(2), .OVERLAP(1)) u2 (
    .clk(clk), .rst(rst), .en(en), .din(din), .pattern(pattern), .mask(mask),
    .cnt_clr(cnt_clr), .match(match2), .score(score2), .match_count(cnt2), .primed(primed2));

  // Behavioural model: bit history (index 0 = newest), samples since refill.
  int hist[W];
  int m_score;
  int m_fill[3];
  int m_cnt[3];
  int m_match[3];
  int m_primed[3];
  int m_overlap[3] = '{1, 0, 1};
  int m_cmax[3]    = '{255, 255, 3};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < W; k++) hist[k] = 0;
    m_score = 0;
    for (int i = 0; i < 3; i++) begin
      m_fill[i] = 0; m_cnt[i] = 0; m_match[i] = 0; m_primed[i] = 0;
    end
  endtask

  task automatic model_step();
    int full;
    int fn;
    int hit;
    if (rst) begin
      model_reset();
      return;
    end
    if (en) begin
      for (int k = W - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = int'(din);
      full = 1;
      m_score = 0;
      for (int k = 0; k < W; k++) begin
        if (mask[k]) begin
          if (hist[k] == int'(pattern[k])) m_score++;
          else full = 0;
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      hit = 0;
      if (en) begin
        fn = (m_fill[i] + 1 > W) ? W : m_fill[i] + 1;
        hit = (full != 0 && fn == W) ? 1 : 0;
        m_fill[i] = (hit != 0 && m_overlap[i] == 0) ? 0 : fn;
        m_primed[i] = (m_fill[i] == W) ? 1 : 0;
      end
      m_match[i] = hit;
      if (cnt_clr) m_cnt[i] = hit;
      else if (hit != 0 && m_cnt[i] < m_cmax[i]) m_cnt[i]++;
    end
  endtask

  // One clock: drive inputs, then advance the model on the edge.
  task automatic cyc(input bit e, input bit d, input bit clr = 1'b0, input bit r = 1'b0);
    rst = r; en = e; din = d; cnt_clr = clr;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic send(input bit d);
    cyc(1'b1, d);
  endtask

  // Every-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("u0.match", int'(match0), m_match[0]);
      chk("u1.match", int'(match1), m_match[1]);
      chk("u2.match", int'(match2), m_match[2]);
      chk("u0.score", int'(score0), m_score);
      chk("u1.score", int'(score1), m_score);
      chk("u2.score", int'(score2), m_score);
      chk("u0.count", int'(cnt0), m_cnt[0]);
      chk("u1.count", int'(cnt1), m_cnt[1]);
      chk("u2.count", int'(cnt2), m_cnt[2]);
      chk("u0.primed", int'(primed0), m_primed[0]);
      chk("u1.primed", int'(primed1), m_primed[1]);
      chk("u2.primed", int'(primed2), m_primed[2]);
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; din = 1'b0; cnt_clr = 1'b0;
    pattern = 4'b1011; mask = 4'b1111;
    model_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk_on = 1'b1;
    chk("reset_match", int'(match0), 0);
    chk("reset_count", int'(cnt0), 0);
    chk("reset_primed", int'(primed0), 0);

    // Basic match, then overlapping second match.
    send(1'b1); send(1'b0); send(1'b1);
    chk("tp1_no_early_match", int'(match0), 0);
    send(1'b1);
    chk("tp1_match", int'(match0), 1);
    chk("tp1_score", int'(score0), 4);
    chk("tp1_count", int'(cnt0), 1);
    chk("tp1_primed", int'(primed0), 1);
    chk("tp1_nov_primed", int'(primed1), 0);
    send(1'b0);
    chk("tp1_pulse_end", int'(match0), 0);
    send(1'b1); send(1'b1);
    chk("tp2_match", int'(match0), 1);
    chk("tp2_count", int'(cnt0), 2);
    chk("tp2_nov_nomatch", int'(match1), 0);
    chk("tp2_nov_count", int'(cnt1), 1);

    // Don't-care LSB.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    mask = 4'b1110;
    send(1'b1); send(1'b0); send(1'b1); send(1'b0);
    chk("tp3_masked_match", int'(match0), 1);
    chk("tp3_masked_score", int'(score0), 3);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    mask = 4'b1111;
    send(1'b1); send(1'b0); send(1'b1); send(1'b0);
    chk("tp3_full_nomatch", int'(match0), 0);
    chk("tp3_full_score", int'(score0), 3);

    // Enable gaps between samples.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    send(1'b1); cyc(1'b0, 1'b1); cyc(1'b0, 1'b1);
    send(1'b0); cyc(1'b0, 1'b1); cyc(1'b0, 1'b1);
    send(1'b1); cyc(1'b0, 1'b0); cyc(1'b0, 1'b1);
    chk("tp4_gap_score", int'(score0), 1);
    chk("tp4_gap_nomatch", int'(match0), 0);
    send(1'b1);
    chk("tp4_match", int'(match0), 1);
    cyc(1'b0, 1'b1);
    chk("tp4_gap_deassert", int'(match0), 0);
    chk("tp4_gap_hold_score", int'(score0), 4);

    // Saturation on a narrow counter, then clear coincident with a hit.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    pattern = 4'b1111;
    for (int i = 0; i < 8; i++) send(1'b1);
    chk("tp5_count_wide", int'(cnt0), 5);
    chk("tp5_count_sat", int'(cnt2), 3);
    chk("tp5_count_nov", int'(cnt1), 2);
    cyc(1'b1, 1'b1, 1'b1);
    chk("tp5_clr_hit", int'(cnt2), 1);
    chk("tp5_clr_hit_wide", int'(cnt0), 1);
    cyc(1'b1, 1'b0, 1'b1);
    chk("tp5_clr_nohit", int'(cnt0), 0);

    // Reset mid-stream.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    pattern = 4'b1011;
    send(1'b1); send(1'b0); send(1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    chk("tp6_rst_score", int'(score0), 0);
    chk("tp6_rst_primed", int'(primed0), 0);
    send(1'b1);
    chk("tp6_nomatch", int'(match0), 0);
    chk("tp6_primed", int'(primed0), 0);
    send(1'b0); send(1'b1); send(1'b1);
    chk("tp6_match", int'(match0), 1);

    // All-don't-care mask: every primed sample hits with zero score.
    mask = 4'b0000;
    send(1'b0);
    chk("mask0_match", int'(match0), 1);
    chk("mask0_score", int'(score0), 0);

    // Mixed stream with live pattern/mask changes.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 200; i++) begin
      if (i % 17 == 0) pattern = W'($urandom_range(0, 15));
      if (i % 23 == 0) mask = W'($urandom_range(0, 15));
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 79) == 0));
    end

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xnor_pattern_matcher.md
Name: xnor_pattern_matcher

Overview:
Parametrised serial pattern matcher built on the bitwise XNOR equality primitive. It shifts a 1-bit input stream into a WIDTH-bit window and compares the window against a programmable pattern with a per-bit don't-care mask. It registers a match pulse, a similarity score and a saturating match counter. It is the sequential, width-generalised successor of the two-input XNOR gate, and serves as a sequence detector in the logic-design exercise set.

Parameters:
WIDTH, 4, window and pattern length in bits (>= 2)
CNT_W, 8, match counter width
OVERLAP, 1, 1 = overlapping matches allowed; 0 = window refills completely after each match

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous, active-high reset
en  input  1  sample enable; din is shifted in only when en=1
din  input  1  serial data bit
pattern  input  WIDTH  reference pattern; pattern[WIDTH-1] is compared to the oldest bit in the window
mask  input  WIDTH  1 = care, 0 = don't-care per bit position
cnt_clr  input  1  synchronous clear of match_count
match  output  1  one-cycle registered pulse on a full masked match
score  output  $clog2(WIDTH+1)  number of care positions that agree in the current window
match_count  output  CNT_W  saturating count of matches
primed  output  1  window holds WIDTH valid bits since the last reset or refill

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values: window=0, fill=0, match=0, score=0, match_count=0, primed=0. rst overrides all other inputs, including mid-stream; after reset a full WIDTH fresh bits are required before any match.
- Shift on a clk edge with en=1: win_n = {win[WIDTH-2:0], din}, so the newest bit is at LSB and the first-received bit ends up at MSB. Then win <= win_n.
- Fill counter: on en, fill <= min(fill+1, WIDTH). primed = (fill == WIDTH).
- Equality vector: eq = ~(win_n ^ pattern) | ~mask. hit = (&eq) & (fill_n == WIDTH).
- match <= hit on an en edge; match <= 0 on any edge with en=0. Latency: match is high in the cycle after the edge that samples the final pattern bit. It is never high for two cycles unless two consecutive en samples each complete a match.
- score <= popcount(~(win_n ^ pattern) & mask) on each en edge. It holds when en=0 and counts regardless of primed.
- OVERLAP=1: fill stays at WIDTH after a hit, so the next match can complete one bit later.
- OVERLAP=0: on a hit, fill <= 0, and primed drops the cycle after the match. The next match needs WIDTH new en samples, even though window contents are retained.
- match_count: on hit, increment, saturating at 2^CNT_W-1 with no wrap.
- cnt_clr=1: match_count <= (hit ? 1 : 0). The clear applies first and the simultaneous match is still counted.
- mask = all zeros: every primed en sample is a hit, and score = 0.
- pattern and mask are not latched. The values present at each en edge are used. A change mid-stream affects only subsequent edges.
- en=0: window, fill, score and match_count hold; match deasserts.

Test Plan:
- WIDTH=4, OVERLAP=1, pattern=4'b1011, mask=4'b1111; en=1, din 1,0,1,1 -> match=1 exactly one cycle after the 4th edge, score=4, match_count=1, primed=1 after the 4th edge.
- Same setup, stream 1,0,1,1,0,1,1 -> match pulses after bit 4 and bit 7, match_count=2. With OVERLAP=0, same stream -> single pulse after bit 4, match_count=1, primed=0 after bit 4.
- pattern=4'b1011, mask=4'b1110, stream 1,0,1,0 -> match=1, score=3. With mask=4'b1111 the same stream gives match=0 and score=3.
- Stream 1,0,1,1 with en=0 for 2 cycles between each bit -> a single match pulse after the final en edge, and no match or score change during gaps.
- CNT_W=2, OVERLAP=1, pattern=4'b1111, stream of 8 ones -> 5 matches, match_count saturates at 3. Assert cnt_clr together with a hit -> match_count=1.
- Stream 1,0,1 then rst for one cycle, then 1 -> no match, fill=1, primed=0, all outputs 0 after the reset edge. Then 0,1,1 -> match.
